// File: rtl/fifo_scan_param.sv
// fifo_scan_param: parametrised synchronous FIFO with registered request inputs,
// occupancy/level flags, sticky overflow/underflow and a mux-D scan chain that
// covers every control and datapath flop except the storage array.
module fifo_scan_param #(
    parameter int unsigned DATA_W   = 17,
    parameter int unsigned DEPTH    = 8,
    parameter int unsigned AF_LEVEL = DEPTH - 2,
    parameter int unsigned AE_LEVEL = 2,
    localparam int unsigned AW      = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              w_en,
    input  logic              r_en,
    input  logic [DATA_W-1:0] data_in,
    input  logic              clr_err,
    output logic [DATA_W-1:0] data_out,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic [AW:0]       count,
    output logic              overflow,
    output logic              underflow,
    input  logic              TM,
    input  logic              SI,
    output logic              SO
);

    localparam int unsigned CW = AW + 1;
    // Scan chain length excluding the SO flop.
    localparam int unsigned CH = 2 * CW + 2 * DATA_W + 4;

    localparam logic [AW:0] DEPTH_C = CW'(DEPTH);
    localparam logic [AW:0] AF_C    = CW'(AF_LEVEL);
    localparam logic [AW:0] AE_C    = CW'(AE_LEVEL);
    localparam logic [AW:0] ONE_C   = CW'(1);

    // Registered state
    logic              r_en_q, r_en_d;
    logic              w_en_q, w_en_d;
    logic [AW:0]       r_ptr_q, r_ptr_d;
    logic [AW:0]       w_ptr_q, w_ptr_d;
    logic [DATA_W-1:0] din_q, din_d;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic              ovf_q, ovf_d;
    logic              udf_q, udf_d;
    logic              so_q, so_d;

    // Storage (not reset, not scanned)
    logic [DATA_W-1:0] mem [DEPTH];

    // Status and handshake terms
    logic [AW:0]       count_w;
    logic              full_w;
    logic              empty_w;
    logic              rd_ok;
    logic              wr_ok;
    logic [CH-1:0]     chain_cur;
    logic [CH-1:0]     chain_nxt;

    // Occupancy and flags straight from the pointers (also valid while shifting).
    always_comb begin
        count_w = w_ptr_q - r_ptr_q;
        full_w  = (count_w == DEPTH_C);
        empty_w = (count_w == '0);
        rd_ok   = r_en_q & ~empty_w;
        wr_ok   = w_en_q & (~full_w | rd_ok);
    end

    // Chain vector: bit 0 is nearest SI, the top bit (underflow) feeds SO.
    always_comb begin
        chain_cur = {udf_q, ovf_q, dout_q, din_q, w_ptr_q, r_ptr_q, w_en_q, r_en_q};
        chain_nxt = {chain_cur[CH-2:0], SI};
    end

    // Next-state selection: one-position shift in scan mode, FIFO behaviour otherwise.
    always_comb begin
        r_en_d  = r_en_q;
        w_en_d  = w_en_q;
        r_ptr_d = r_ptr_q;
        w_ptr_d = w_ptr_q;
        din_d   = din_q;
        dout_d  = dout_q;
        ovf_d   = ovf_q;
        udf_d   = udf_q;
        so_d    = so_q;

        if (TM) begin
            {udf_d, ovf_d, dout_d, din_d, w_ptr_d, r_ptr_d, w_en_d, r_en_d} = chain_nxt;
            so_d = udf_q;
        end else begin
            r_en_d = r_en;
            w_en_d = w_en;
            din_d  = data_in;

            if (rd_ok) begin
                dout_d  = mem[r_ptr_q[AW-1:0]];
                r_ptr_d = r_ptr_q + ONE_C;
            end

            if (wr_ok) begin
                w_ptr_d = w_ptr_q + ONE_C;
            end

            // Set condition takes priority over the clear.
            if (w_en_q && full_w && !rd_ok) begin
                ovf_d = 1'b1;
            end else if (clr_err) begin
                ovf_d = 1'b0;
            end

            if (r_en_q && empty_w) begin
                udf_d = 1'b1;
            end else if (clr_err) begin
                udf_d = 1'b0;
            end
        end
    end

    // Control and datapath flops, all on the scan chain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_en_q  <= 1'b0;
            w_en_q  <= 1'b0;
            r_ptr_q <= '0;
            w_ptr_q <= '0;
            din_q   <= '0;
            dout_q  <= '0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
            so_q    <= 1'b0;
        end else begin
            r_en_q  <= r_en_d;
            w_en_q  <= w_en_d;
            r_ptr_q <= r_ptr_d;
            w_ptr_q <= w_ptr_d;
            din_q   <= din_d;
            dout_q  <= dout_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
            so_q    <= so_d;
        end
    end

    // Storage write; suppressed while shifting so scanned pointer bits cannot corrupt it.
    always_ff @(posedge clk) begin
        if (!TM && wr_ok) begin
            mem[w_ptr_q[AW-1:0]] <= din_q;
        end
    end

    // Output drive
    always_comb begin
        data_out     = dout_q;
        count        = count_w;
        full         = full_w;
        empty        = empty_w;
        almost_full  = (count_w >= AF_C);
        almost_empty = (count_w <= AE_C);
        overflow     = ovf_q;
        underflow    = udf_q;
        SO           = so_q;
    end

endmodule
